// File: rtl/axi4_sram_responder.sv
// AXI4 slave responder over a word-addressed SRAM; serves one read or write burst at a time.
// Optional random handshake stalls are enabled by defining AXI_SRAM_DELAY_EN.
module axi4_sram_responder #(
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter int unsigned DEPTH     = 4096
) (
    input  logic        clock,
    input  logic        reset,
    output logic        awready,
    input  logic        awvalid,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    output logic        wready,
    input  logic        wvalid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        bready,
    output logic        bvalid,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        arready,
    input  logic        arvalid,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        rready,
    output logic        rvalid,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast
);

    localparam int unsigned IdxW      = $clog2(DEPTH);
    localparam logic [32:0] SpanBytes = 33'(DEPTH) << 2;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;
    localparam logic [1:0] RespDecErr = 2'b11;

    typedef enum logic [1:0] {StIdle, StRd, StWr, StBresp} state_e;

    function automatic logic in_range(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return (a >= BASE_ADDR) && ({1'b0, off} < SpanBytes);
    endfunction

    function automatic logic [IdxW-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = (a - BASE_ADDR) >> 2;
        return off[IdxW-1:0];
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] step;
        logic [31:0] win;
        logic [31:0] nxt;
        step = 32'd1 << size;
        win  = ({24'd0, len} + 32'd1) << size;
        nxt  = a + step;
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~(win - 32'd1)) | (nxt & (win - 32'd1));
            default: return nxt;
        endcase
    endfunction

    function automatic logic burst_err(input logic [7:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        logic bad_wrap;
        bad_wrap = (burst == 2'b10) &&
                   !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return (size > 3'd2) || (burst == 2'b11) || bad_wrap;
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        dec_q, dec_d;
    logic        last_wr_q, last_wr_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic        rlast_q, rlast_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;

    logic [31:0] mem_q [DEPTH];
    logic        mem_we;
    logic [IdxW-1:0] mem_idx;

    logic go;
`ifdef AXI_SRAM_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    always_ff @(posedge clock) begin
        if (!reset) lfsr_q <= 8'hA5;
        else        lfsr_q <= lfsr_d;
    end
    assign go = lfsr_q[0];
`else
    assign go = 1'b1;
`endif

    // Round-robin tie-break: last_wr_q=1 means the write channel was served last.
    logic grant_rd, grant_wr;
    logic ar_hs, aw_hs, w_hs;
    assign grant_rd = arvalid && (!awvalid || last_wr_q);
    assign grant_wr = awvalid && (!arvalid || !last_wr_q);
    assign arready  = reset && (state_q == StIdle) && grant_rd && go;
    assign awready  = reset && (state_q == StIdle) && grant_wr && go;
    assign wready   = reset && (state_q == StWr) && go;
    assign ar_hs    = arvalid && arready;
    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;

    // Read beat source: the AR request in IDLE, otherwise the burst's next address.
    logic [31:0] ld_addr;
    logic        ld_err;
    logic [1:0]  ld_resp;
    logic [31:0] ld_data;
    assign ld_addr = (state_q == StIdle) ? araddr : addr_q;
    assign ld_err  = (state_q == StIdle) ? burst_err(arlen, arsize, arburst) : err_q;
    assign ld_resp = ld_err ? RespSlvErr : (!in_range(ld_addr) ? RespDecErr : RespOkay);
    assign ld_data = (ld_resp == RespOkay) ? mem_q[word_idx(ld_addr)] : 32'd0;

    always_comb begin
        logic beat_ok;
        logic len_bad;
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        size_d    = size_q;
        burst_d   = burst_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        dec_d     = dec_q;
        last_wr_d = last_wr_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        rlast_d   = rlast_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        mem_we    = 1'b0;
        mem_idx   = word_idx(addr_q);
        beat_ok   = in_range(addr_q);
        len_bad   = wlast ? (cnt_q != len_q) : (cnt_q >= len_q);

        unique case (state_q)
            StIdle: begin
                if (ar_hs) begin
                    state_d   = StRd;
                    id_d      = arid;
                    len_d     = arlen;
                    size_d    = arsize;
                    burst_d   = arburst;
                    err_d     = burst_err(arlen, arsize, arburst);
                    addr_d    = next_addr(araddr, arlen, arsize, arburst);
                    cnt_d     = 8'd0;
                    rdata_d   = ld_data;
                    rresp_d   = ld_resp;
                    rlast_d   = (arlen == 8'd0);
                    rvalid_d  = go;
                    last_wr_d = 1'b0;
                end else if (aw_hs) begin
                    state_d   = StWr;
                    id_d      = awid;
                    len_d     = awlen;
                    size_d    = awsize;
                    burst_d   = awburst;
                    err_d     = burst_err(awlen, awsize, awburst);
                    dec_d     = 1'b0;
                    addr_d    = awaddr;
                    cnt_d     = 8'd0;
                    last_wr_d = 1'b1;
                end
            end
            StRd: begin
                if (!rvalid_q) begin
                    rvalid_d = go;
                end else if (rready) begin
                    if (rlast_q) begin
                        state_d  = StIdle;
                        rvalid_d = 1'b0;
                    end else begin
                        rdata_d = ld_data;
                        rresp_d = ld_resp;
                        rlast_d = ((cnt_q + 8'd1) == len_q);
                        cnt_d   = cnt_q + 8'd1;
                        addr_d  = next_addr(addr_q, len_q, size_q, burst_q);
                    end
                end
            end
            StWr: begin
                if (w_hs) begin
                    // Beats past the announced length are consumed but never written.
                    mem_we = !err_q && beat_ok && (cnt_q <= len_q);
                    err_d  = err_q | len_bad;
                    dec_d  = dec_q | (!beat_ok && (cnt_q <= len_q));
                    addr_d = next_addr(addr_q, len_q, size_q, burst_q);
                    cnt_d  = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
                    if (wlast) begin
                        state_d  = StBresp;
                        bvalid_d = go;
                        bresp_d  = err_d ? RespSlvErr : (dec_d ? RespDecErr : RespOkay);
                    end
                end
            end
            StBresp: begin
                if (!bvalid_q) begin
                    bvalid_d = go;
                end else if (bready) begin
                    bvalid_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StIdle;
            id_q      <= 4'd0;
            addr_q    <= 32'd0;
            len_q     <= 8'd0;
            size_q    <= 3'd0;
            burst_q   <= 2'd0;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            dec_q     <= 1'b0;
            last_wr_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= 32'd0;
            rresp_q   <= 2'd0;
            rlast_q   <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            dec_q     <= dec_d;
            last_wr_q <= last_wr_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
        end
    end

    // Array has no reset so contents survive a reset pulse.
    always_ff @(posedge clock) begin
        if (reset && mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem_q[mem_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign rlast  = rlast_q;
    assign rid    = id_q;
    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign bid    = id_q;

endmodule
